uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the core's UART transmitter.
- Synchronises the asynchronous RX pin, detects the start bit, samples each bit at mid-bit and assembles the byte LSB-first.
- Presents the byte to the core through a hold-until-read valid/read handshake.
- Flags framing errors and overruns; sits beside the transmitter on the same system clock.

Parameters:
- CLKS_PER_BIT, 104, system clocks per UART bit; must be ≥ 4. Default matches the transmitter's bit period.

Ports:
- clock  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- uartRxPin  input  1  asynchronous serial line; idles high
- re  input  1  read strobe; consumes the held byte when rxValid=1
- rxData  output  8  received byte; valid while rxValid=1
- rxValid  output  1  byte held and unread
- frameError  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while the previous byte was still unread
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - state=IDLE, bit counter=0, clock counter=0.
  - Synchroniser flops=1.
  - rxData=8'h00, rxValid=0, frameError=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame, with no partial byte or flag.
- Synchroniser: two flops on uartRxPin; `rxs` is the second flop output. All decisions use rxs, giving 2-cycle input latency.
- Clock counter: counts 0..CLKS_PER_BIT-1. It clears on every state entry and after every sample.
- FSM:
  - IDLE: when rxs=0 and the previous rxs=1 (falling edge), go to START and clear the counter.
  - START: when the counter reaches CLKS_PER_BIT/2-1 (integer divide), sample rxs.
    - rxs=1: glitch. Return to IDLE with no flag.
    - rxs=0: go to DATA, with bit counter=0.
  - DATA: each time the counter reaches CLKS_PER_BIT-1, sample rxs into the shift register at bit position [bit counter], LSB first. After bit 7 is sampled, go to STOP.
  - STOP: when the counter reaches CLKS_PER_BIT-1, sample rxs.
    - rxs=1: deliver the byte, go to IDLE.
    - rxs=0: pulse frameError for one cycle, discard the byte, go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. A held-low line produces exactly one frameError.
- Delivery (the cycle after the stop sample):
  - rxValid=0, or rxValid=1 with re=1 in the same cycle: load rxData and set rxValid=1. No overrun.
  - rxValid=1 with re=0: keep the old rxData and rxValid, drop the new byte, pulse overrun for one cycle.
- Read: re=1 while rxValid=1 clears rxValid on the next edge, unless a delivery happens in the same cycle (see above). re while rxValid=0 is ignored.
- The next falling edge is accepted immediately on return to IDLE after the mid-stop sample. Back-to-back frames are received without loss.
- rxData must not change while rxValid=1 except on a same-cycle read and delivery.
- Latency:
  - Start-bit edge on the pin to start-bit sample: 2 + CLKS_PER_BIT/2 clocks.
  - Stop-bit sample to rxValid=1: 1 clock.

Test Plan:
1. CLKS_PER_BIT=16. Send 8'hA5 8N1 with exact bit timing → rxValid rises 1 clock after the mid-stop sample; rxData=8'hA5; frameError=0. re=1 for one cycle → rxValid=0 on the next edge.
2. Pulse uartRxPin low for 4 clocks (less than half a bit) from idle → FSM returns to IDLE; rxValid, frameError and busy all 0 after 10 clocks.
3. Send 8'h3C with the stop bit driven low, then hold the line low for 5 bit times → exactly one frameError pulse, rxValid stays 0. Line returns high, then 8'h81 is sent → rxData=8'h81.
4. Send 8'h11 without reading, then 8'h22 → one overrun pulse; rxData stays 8'h11; rxValid stays 1.
5. Send 8'h11, then 8'h22, with re asserted exactly in the delivery cycle of 8'h22 → no overrun; rxData=8'h22; rxValid=1.
6. Assert reset for 1 clock mid-way through the data bits of 8'hFF, then send 8'h5A → all outputs at reset values after reset; next byte received as 8'h5A with no errors. Also check back-to-back 8'h00, 8'hFF at ±2% bit-rate skew → both bytes received.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop pin synchroniser, mid-bit sampling, LSB-first
// assembly, hold-until-read output with framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uartRxPin,
  input  logic       re,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       frameError,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rxs_q, rxs_d;
  logic             rxs_prev_q, rxs_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  // State and datapath registers with synchronous reset; line idles high
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      rxs_prev_q  <= rxs_prev_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, bit sampling, delivery and read handshake
  always_comb begin
    state_d     = state_q;
    sync1_d     = uartRxPin;
    rxs_d       = sync1_q;
    rxs_prev_d  = rxs_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (re && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q && rxs_prev_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs_q;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
            // A read in the same cycle frees the holding register for the new byte
            if (!rx_valid_q || re) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            shift_d     = '0;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rxData     = rx_data_q;
  assign rxValid    = rx_valid_q;
  assign frameError = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with an expected-byte scoreboard.
module tb_uart_rx;

  localparam int CPB = 16;
  // Pin edge to start sample (2 + CPB/2), nine bit periods to the stop sample, one clock to rxValid
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;
  localparam int P_NOM = CPB * 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uartRxPin = 1'b1;
  logic       re = 1'b0;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameError;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int cyc = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic prev_valid = 1'b0;
  int fe_base;
  int ov_base;

  logic [7:0] sb[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .uartRxPin  (uartRxPin),
    .re         (re),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .frameError (frameError),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse counters and rxValid rise timestamp
  always @(negedge clock) begin
    if (rxValid && !prev_valid) rise_cyc = cyc;
    prev_valid = rxValid;
    if (frameError) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rxData"}, 32'(rxData), 32'h00);
    check({tag, " rxValid"}, 32'(rxValid), 32'h0);
    check({tag, " frameError"}, 32'(frameError), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
  endtask

  // Drive one 8N1 frame; p100 is the bit period in hundredths of a clock
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p100,
                            input int re_at, input int rst_at);
    logic [9:0] f;
    int t;
    f = {stop_bit, b, 1'b0};
    t = 0;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      int e;
      e = ((i + 1) * p100 + 50) / 100;
      while (t < e) begin
        if (rst_at >= 0 && t == rst_at + 1) check_reset_outputs("mid-frame reset");
        uartRxPin = f[i];
        if (re_at >= 0) re = (t == re_at);
        if (rst_at >= 0) reset = (t == rst_at);
        @(negedge clock);
        t++;
      end
    end
    uartRxPin = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!rxValid && n < 400) begin
      @(negedge clock);
      n++;
    end
    check({tag, " rxValid"}, 32'(rxValid), 32'h1);
  endtask

  task automatic check_data(input string tag);
    logic [7:0] exp;
    check({tag, " scoreboard nonempty"}, 32'(sb.size() > 0), 32'h1);
    exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    check({tag, " rxData"}, 32'(rxData), 32'(exp));
  endtask

  task automatic pulse_re();
    re = 1'b1;
    @(negedge clock);
    re = 1'b0;
  endtask

  task automatic read_byte(input string tag);
    wait_valid(tag);
    check_data(tag);
    pulse_re();
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    check("reset overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // 1: single byte, latency and read clear
    fe_base = fe_cnt;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, P_NOM, -1, -1);
    wait_valid("t1");
    check("t1 latency", 32'(rise_cyc - start_cyc), 32'(LAT));
    check_data("t1");
    check("t1 frameError", 32'(fe_cnt - fe_base), 32'h0);
    pulse_re();
    check("t1 rxValid after read", 32'(rxValid), 32'h0);
    repeat (CPB) @(negedge clock);

    // 2: short glitch rejected
    uartRxPin = 1'b0;
    repeat (4) @(negedge clock);
    uartRxPin = 1'b1;
    repeat (10) @(negedge clock);
    check("t2 rxValid", 32'(rxValid), 32'h0);
    check("t2 frameError", 32'(fe_cnt - fe_base), 32'h0);
    check("t2 busy", 32'(busy), 32'h0);
    repeat (CPB) @(negedge clock);

    // 3: framing error followed by a held-low line, then recovery
    fe_base = fe_cnt;
    send_frame(8'h3C, 1'b0, P_NOM, -1, -1);
    uartRxPin = 1'b0;
    repeat (5 * CPB) @(negedge clock);
    uartRxPin = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    check("t3 frameError pulses", 32'(fe_cnt - fe_base), 32'h1);
    check("t3 rxValid", 32'(rxValid), 32'h0);
    check("t3 busy", 32'(busy), 32'h0);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1, P_NOM, -1, -1);
    read_byte("t3 recover");
    repeat (CPB) @(negedge clock);

    // 4: overrun keeps the unread byte
    ov_base = ov_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, P_NOM, -1, -1);
    wait_valid("t4 first");
    send_frame(8'h22, 1'b1, P_NOM, -1, -1);
    repeat (4) @(negedge clock);
    check("t4 overrun pulses", 32'(ov_cnt - ov_base), 32'h1);
    check("t4 rxValid", 32'(rxValid), 32'h1);
    check_data("t4 held");
    pulse_re();
    repeat (CPB) @(negedge clock);

    // 5: read in the delivery cycle accepts the new byte without overrun
    ov_base = ov_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, P_NOM, -1, -1);
    wait_valid("t5 first");
    check_data("t5 first");
    sb.push_back(8'h22);
    send_frame(8'h22, 1'b1, P_NOM, LAT - 1, -1);
    repeat (4) @(negedge clock);
    check("t5 overrun pulses", 32'(ov_cnt - ov_base), 32'h0);
    check("t5 rxValid", 32'(rxValid), 32'h1);
    check_data("t5 second");
    pulse_re();
    repeat (CPB) @(negedge clock);

    // 6: reset mid-frame, then clean byte, then back-to-back skewed frames
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    send_frame(8'hFF, 1'b1, P_NOM, -1, 5 * CPB);
    reset = 1'b0;
    repeat (CPB) @(negedge clock);
    check("t6 rxValid after reset frame", 32'(rxValid), 32'h0);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, P_NOM, -1, -1);
    read_byte("t6 5A");
    repeat (CPB) @(negedge clock);
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    fork
      begin
        send_frame(8'h00, 1'b1, P_NOM * 102 / 100, -1, -1);
        send_frame(8'hFF, 1'b1, P_NOM * 98 / 100, -1, -1);
      end
      begin
        read_byte("t6 b2b 00");
        read_byte("t6 b2b FF");
      end
    join
    repeat (CPB) @(negedge clock);
    check("t6 frameError", 32'(fe_cnt - fe_base), 32'h0);
    check("t6 overrun", 32'(ov_cnt - ov_base), 32'h0);
    check("t6 scoreboard drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
